// File: rtl/cpu_boot_sequencer.sv
// cpu_boot_sequencer: streams a program into CPU instruction memory while the
// CPU is held in reset, lets the writes settle, releases the CPU for a bounded
// (or unbounded) number of cycles, then parks it back in reset.
module cpu_boot_sequencer #(
  parameter int MAX_WORDS     = 64,
  parameter int SETTLE_CYCLES = 4,
  parameter int CNT_W         = $clog2(MAX_WORDS + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [31:0]      run_cycles,
  input  logic             abort,
  input  logic             word_valid,
  input  logic [31:0]      word_data,
  input  logic             word_last,
  output logic             word_ready,
  output logic             initialize,
  output logic [31:0]      instruction_initialize_address,
  output logic [31:0]      instruction_initialize_data,
  output logic             cpu_rst,
  output logic             running,
  output logic             done,
  output logic             error,
  output logic [CNT_W-1:0] word_count
);

  // A settle counter of one bit is enough when only one settle cycle is needed.
  localparam int SET_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SETTLE,
    S_RUN,
    S_HALT
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   word_count_q, word_count_d;
  logic [31:0]        addr_q, addr_d;
  logic [31:0]        data_q, data_d;
  logic               error_q, error_d;
  logic [31:0]        run_len_q, run_len_d;
  logic [31:0]        run_cnt_q, run_cnt_d;
  logic [SET_W-1:0]   settle_cnt_q, settle_cnt_d;

  logic               handshake;
  logic               start_accept;

  // State register and datapath registers; reset parks the CPU in reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      word_count_q <= '0;
      addr_q       <= '0;
      data_q       <= '0;
      error_q      <= 1'b0;
      run_len_q    <= '0;
      run_cnt_q    <= '0;
      settle_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      word_count_q <= word_count_d;
      addr_q       <= addr_d;
      data_q       <= data_d;
      error_q      <= error_d;
      run_len_q    <= run_len_d;
      run_cnt_q    <= run_cnt_d;
      settle_cnt_q <= settle_cnt_d;
    end
  end

  // Next-state logic; abort always wins over a same-cycle handshake or run step.
  always_comb begin
    state_d      = state_q;
    word_count_d = word_count_q;
    addr_d       = addr_q;
    data_d       = data_q;
    error_d      = error_q;
    run_len_d    = run_len_q;
    run_cnt_d    = run_cnt_q;
    settle_cnt_d = settle_cnt_q;
    start_accept = 1'b0;
    handshake    = word_valid && (state_q == S_LOAD);

    case (state_q)
      S_IDLE: begin
        if (start) begin
          start_accept = 1'b1;
        end
      end

      S_LOAD: begin
        if (abort) begin
          state_d = S_HALT;
        end else if (handshake) begin
          addr_d       = 32'(word_count_q) << 2;
          data_d       = word_data;
          word_count_d = word_count_q + CNT_W'(1);
          if (word_last) begin
            state_d      = S_SETTLE;
            settle_cnt_d = '0;
          end else if (word_count_d == CNT_W'(MAX_WORDS)) begin
            state_d = S_HALT;
            error_d = 1'b1;
          end
        end
      end

      S_SETTLE: begin
        if (abort) begin
          state_d = S_HALT;
        end else if (settle_cnt_q == SET_W'(SETTLE_CYCLES - 1)) begin
          state_d   = S_RUN;
          run_cnt_d = '0;
        end else begin
          settle_cnt_d = settle_cnt_q + SET_W'(1);
        end
      end

      S_RUN: begin
        if (abort) begin
          state_d = S_HALT;
        end else begin
          if (run_cnt_q != '1) begin
            run_cnt_d = run_cnt_q + 32'd1;
          end
          if ((run_len_q != '0) && (run_cnt_d == run_len_q)) begin
            state_d = S_HALT;
          end
        end
      end

      S_HALT: begin
        if (start && !abort) begin
          start_accept = 1'b1;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (start_accept) begin
      state_d      = S_LOAD;
      word_count_d = '0;
      error_d      = 1'b0;
      run_len_d    = run_cycles;
      run_cnt_d    = '0;
    end
  end

  // Outputs are decoded from the registered state so reset reaches them at once.
  always_comb begin
    word_ready                     = (state_q == S_LOAD);
    initialize                     = (state_q == S_LOAD) || (state_q == S_SETTLE);
    cpu_rst                        = (state_q != S_RUN);
    running                        = (state_q == S_RUN);
    done                           = (state_q == S_HALT);
    error                          = error_q;
    word_count                     = word_count_q;
    instruction_initialize_address = addr_q;
    instruction_initialize_data    = data_q;
  end

endmodule

// File: tb/tb_cpu_boot_sequencer.sv
`timescale 1ns/1ps
// Bench for cpu_boot_sequencer: a phase/countdown model predicts every output
// each cycle, and directed scenarios pin run lengths and write contents.
module tb_cpu_boot_sequencer;

  localparam int MAXW   = 4;
  localparam int SETTLE = 4;
  localparam int CW     = $clog2(MAXW + 1);

  localparam int PH_IDLE   = 0;
  localparam int PH_LOAD   = 1;
  localparam int PH_SETTLE = 2;
  localparam int PH_RUN    = 3;
  localparam int PH_HALT   = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [31:0]   run_cycles = '0;
  logic          abort = 1'b0;
  logic          word_valid = 1'b0;
  logic [31:0]   word_data = '0;
  logic          word_last = 1'b0;
  logic          word_ready;
  logic          initialize;
  logic [31:0]   instruction_initialize_address;
  logic [31:0]   instruction_initialize_data;
  logic          cpu_rst;
  logic          running;
  logic          done;
  logic          error;
  logic [CW-1:0] word_count;

  int checksTotal  = 0;
  int checksPassed = 0;
  bit compareEn    = 1'b0;
  int lowCount     = 0;
  int settleSeen   = 0;

  logic [31:0] prog [0:7];
  logic [31:0] mem  [0:15];

  // Model state: phase plus countdown/elapsed counters.
  int          mPhase;
  int          mCount;
  int          mSettleLeft;
  int          mElapsed;
  logic [31:0] mRunLen;
  logic [31:0] mAddr;
  logic [31:0] mData;
  logic        mErr;

  cpu_boot_sequencer #(
    .MAX_WORDS    (MAXW),
    .SETTLE_CYCLES(SETTLE)
  ) dut (
    .clk                           (clk),
    .rst                           (rst),
    .start                         (start),
    .run_cycles                    (run_cycles),
    .abort                         (abort),
    .word_valid                    (word_valid),
    .word_data                     (word_data),
    .word_last                     (word_last),
    .word_ready                    (word_ready),
    .initialize                    (initialize),
    .instruction_initialize_address(instruction_initialize_address),
    .instruction_initialize_data   (instruction_initialize_data),
    .cpu_rst                       (cpu_rst),
    .running                       (running),
    .done                          (done),
    .error                         (error),
    .word_count                    (word_count)
  );

  always #5 clk = ~clk;

  // Stand-in for the CPU instruction memory: writes whenever initialize is high.
  always @(posedge clk) begin
    if (initialize) mem[instruction_initialize_address[5:2]] <= instruction_initialize_data;
  end

  task automatic modelBeginLoad();
    mPhase   = PH_LOAD;
    mCount   = 0;
    mErr     = 1'b0;
    mRunLen  = run_cycles;
    mElapsed = 0;
  endtask

  // Behavioural model: what the sequencer must do at each rising edge.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      mPhase = PH_IDLE; mCount = 0; mSettleLeft = 0; mElapsed = 0;
      mRunLen = '0; mAddr = '0; mData = '0; mErr = 1'b0;
    end else begin
      case (mPhase)
        PH_IDLE: if (start) modelBeginLoad();
        PH_LOAD: begin
          if (abort) mPhase = PH_HALT;
          else if (word_valid) begin
            mAddr  = 32'(mCount * 4);
            mData  = word_data;
            mCount = mCount + 1;
            if (word_last) begin
              mPhase      = PH_SETTLE;
              mSettleLeft = SETTLE;
            end else if (mCount == MAXW) begin
              mPhase = PH_HALT;
              mErr   = 1'b1;
            end
          end
        end
        PH_SETTLE: begin
          if (abort) mPhase = PH_HALT;
          else begin
            mSettleLeft = mSettleLeft - 1;
            if (mSettleLeft == 0) begin
              mPhase   = PH_RUN;
              mElapsed = 0;
            end
          end
        end
        PH_RUN: begin
          if (abort) mPhase = PH_HALT;
          else begin
            mElapsed = mElapsed + 1;
            if (mRunLen != 0 && 32'(mElapsed) == mRunLen) mPhase = PH_HALT;
          end
        end
        PH_HALT: if (start && !abort) modelBeginLoad();
        default: mPhase = PH_IDLE;
      endcase
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checksTotal++;
    if (act !== exp)
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    else
      checksPassed++;
  endtask

  // Every falling edge: compare all outputs to the model and tally cycle stats.
  always @(negedge clk) begin
    if (compareEn && rst) begin
      checkOutput("word_ready", 32'(word_ready), 32'(mPhase == PH_LOAD));
      checkOutput("initialize", 32'(initialize), 32'(mPhase == PH_LOAD || mPhase == PH_SETTLE));
      checkOutput("cpu_rst", 32'(cpu_rst), 32'(mPhase != PH_RUN));
      checkOutput("running", 32'(running), 32'(mPhase == PH_RUN));
      checkOutput("done", 32'(done), 32'(mPhase == PH_HALT));
      checkOutput("error", 32'(error), 32'(mErr));
      checkOutput("word_count", 32'(word_count), 32'(mCount));
      checkOutput("address", instruction_initialize_address, mAddr);
      checkOutput("data", instruction_initialize_data, mData);
      if (!cpu_rst) lowCount++;
      if (initialize && !word_ready) settleSeen++;
    end
  end

  task automatic applyStimulus(input logic st, input logic [31:0] rc, input logic ab,
                               input logic v, input logic [31:0] d, input logic l);
    @(negedge clk);
    start = st; run_cycles = rc; abort = ab;
    word_valid = v; word_data = d; word_last = l;
  endtask

  task automatic idle();
    applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, 1'b0);
  endtask

  // Offers prog[0..n-1] following a valid pattern; advances only on handshakes.
  task automatic loadProgram(input int n, input logic [15:0] pat, input int len,
                             input bit lastFlag, output int accepted, output int readyCnt);
    int idx = 0;
    readyCnt = 0;
    for (int i = 0; i < len; i++) begin
      logic v;
      v = pat[i] && (idx < n);
      applyStimulus(1'b0, '0, 1'b0, v, prog[(idx < n) ? idx : 0], lastFlag && (idx == n - 1));
      if (word_ready) readyCnt++;
      if (v && word_ready) idx++;
    end
    accepted = idx;
    idle();
  endtask

  task automatic waitHalt(input int bound, input string name);
    for (int i = 0; i < bound; i++) begin
      if (done) break;
      idle();
    end
    #1;
    checkOutput(name, 32'(done), 32'd1);
  endtask

  task automatic waitRunning(input int bound, input string name);
    for (int i = 0; i < bound; i++) begin
      if (running) break;
      idle();
    end
    checkOutput(name, 32'(running), 32'd1);
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, " cpu_rst"}, 32'(cpu_rst), 32'd1);
    checkOutput({tag, " initialize"}, 32'(initialize), 32'd0);
    checkOutput({tag, " address"}, instruction_initialize_address, 32'd0);
    checkOutput({tag, " data"}, instruction_initialize_data, 32'd0);
    checkOutput({tag, " running"}, 32'(running), 32'd0);
    checkOutput({tag, " done"}, 32'(done), 32'd0);
    checkOutput({tag, " error"}, 32'(error), 32'd0);
    checkOutput({tag, " word_count"}, 32'(word_count), 32'd0);
    checkOutput({tag, " word_ready"}, 32'(word_ready), 32'd0);
  endtask

  task automatic clearMem();
    for (int i = 0; i < 16; i++) mem[i] = 32'hDEAD_BEEF;
  endtask

  // Watchdog so the run can never hang.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  // Directed scenarios.
  initial begin
    int acc, rdy, runSeen;

    #1 rst = 1'b0;
    #2 checkResetOutputs("reset");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    compareEn = 1'b1;

    // Three-word program, run 10 cycles; abort in IDLE must be ignored.
    prog[0] = 32'h0002_1020; prog[1] = 32'h0084_4022; prog[2] = 32'h00A6_3825;
    clearMem();
    lowCount = 0; settleSeen = 0;
    applyStimulus(1'b1, 32'd10, 1'b1, 1'b0, '0, 1'b0);
    loadProgram(3, 16'b111, 3, 1'b1, acc, rdy);
    waitHalt(60, "t1 reaches halt");
    checkOutput("t1 accepted", 32'(acc), 32'd3);
    checkOutput("t1 ready cycles", 32'(rdy), 32'd3);
    checkOutput("t1 settle cycles", 32'(settleSeen), 32'd4);
    checkOutput("t1 cpu_rst low cycles", 32'(lowCount), 32'd10);
    checkOutput("t1 word_count", 32'(word_count), 32'd3);
    checkOutput("t1 running", 32'(running), 32'd0);
    checkOutput("t1 mem0", mem[0], 32'h0002_1020);
    checkOutput("t1 mem1", mem[1], 32'h0084_4022);
    checkOutput("t1 mem2", mem[2], 32'h00A6_3825);

    // Same program with gaps in word_valid.
    clearMem();
    lowCount = 0;
    applyStimulus(1'b1, 32'd10, 1'b0, 1'b0, '0, 1'b0);
    loadProgram(3, 16'b101001, 6, 1'b1, acc, rdy);
    waitHalt(60, "t2 reaches halt");
    checkOutput("t2 accepted", 32'(acc), 32'd3);
    checkOutput("t2 ready cycles", 32'(rdy), 32'd6);
    checkOutput("t2 cpu_rst low cycles", 32'(lowCount), 32'd10);
    checkOutput("t2 mem0", mem[0], 32'h0002_1020);
    checkOutput("t2 mem1", mem[1], 32'h0084_4022);
    checkOutput("t2 mem2", mem[2], 32'h00A6_3825);
    checkOutput("t2 mem3 untouched", mem[3], 32'hDEAD_BEEF);

    // Overflow: five words, no last, capacity four.
    prog[0] = 32'h1111_0000; prog[1] = 32'h2222_0000; prog[2] = 32'h3333_0000;
    prog[3] = 32'h4444_0000; prog[4] = 32'h5555_0000;
    lowCount = 0;
    applyStimulus(1'b1, 32'd10, 1'b0, 1'b0, '0, 1'b0);
    loadProgram(5, 16'b11111, 5, 1'b0, acc, rdy);
    idle(); #1;
    checkOutput("t3 accepted", 32'(acc), 32'd4);
    checkOutput("t3 ready cycles", 32'(rdy), 32'd4);
    checkOutput("t3 error", 32'(error), 32'd1);
    checkOutput("t3 done", 32'(done), 32'd1);
    checkOutput("t3 word_count", 32'(word_count), 32'd4);
    checkOutput("t3 word_ready", 32'(word_ready), 32'd0);
    checkOutput("t3 address", instruction_initialize_address, 32'd12);
    checkOutput("t3 cpu_rst never low", 32'(lowCount), 32'd0);
    // start together with abort in HALT keeps HALT and the sticky error.
    applyStimulus(1'b1, 32'd7, 1'b1, 1'b0, '0, 1'b0);
    idle(); #1;
    checkOutput("t3 abort+start done", 32'(done), 32'd1);
    checkOutput("t3 abort+start error", 32'(error), 32'd1);

    // Unbounded run, aborted on the 20th RUN cycle.
    prog[0] = 32'h0000_00AA;
    lowCount = 0; runSeen = 0;
    applyStimulus(1'b1, 32'd0, 1'b0, 1'b0, '0, 1'b0);
    loadProgram(1, 16'b1, 1, 1'b1, acc, rdy);
    for (int i = 0; i < 200 && runSeen < 20; i++) begin
      if (running) runSeen++;
      if (runSeen < 20) idle();
    end
    checkOutput("t4 run cycles seen", 32'(runSeen), 32'd20);
    abort = 1'b1;
    idle(); #1;
    checkOutput("t4 cpu_rst after abort", 32'(cpu_rst), 32'd1);
    checkOutput("t4 done after abort", 32'(done), 32'd1);
    checkOutput("t4 error cleared", 32'(error), 32'd0);
    checkOutput("t4 cpu_rst low cycles", 32'(lowCount), 32'd20);

    // Asynchronous reset in the middle of a load.
    prog[0] = 32'hA000_0001; prog[1] = 32'hA000_0002;
    applyStimulus(1'b1, 32'd3, 1'b0, 1'b0, '0, 1'b0);
    applyStimulus(1'b0, '0, 1'b0, 1'b1, prog[0], 1'b0);
    applyStimulus(1'b0, '0, 1'b0, 1'b1, prog[1], 1'b0);
    @(posedge clk);
    #1 rst = 1'b0;
    #2 checkResetOutputs("midload reset");
    #1 rst = 1'b1;
    prog[0] = 32'hCAFE_0001;
    clearMem();
    lowCount = 0;
    applyStimulus(1'b1, 32'd3, 1'b0, 1'b0, '0, 1'b0);
    loadProgram(1, 16'b1, 1, 1'b1, acc, rdy);
    waitHalt(40, "t5 reaches halt");
    checkOutput("t5 address", instruction_initialize_address, 32'd0);
    checkOutput("t5 data", instruction_initialize_data, 32'hCAFE_0001);
    checkOutput("t5 error", 32'(error), 32'd0);
    checkOutput("t5 word_count", 32'(word_count), 32'd1);
    checkOutput("t5 mem0", mem[0], 32'hCAFE_0001);
    checkOutput("t5 cpu_rst low cycles", 32'(lowCount), 32'd3);

    // Restart from HALT with run length 5; start during RUN is ignored.
    prog[0] = 32'hBEEF_0010; prog[1] = 32'hBEEF_0020;
    clearMem();
    lowCount = 0;
    applyStimulus(1'b1, 32'd5, 1'b0, 1'b0, '0, 1'b0);
    loadProgram(2, 16'b11, 2, 1'b1, acc, rdy);
    waitRunning(20, "t6 reaches run");
    applyStimulus(1'b1, 32'd99, 1'b0, 1'b0, '0, 1'b0);
    waitHalt(40, "t6 reaches halt");
    checkOutput("t6 cpu_rst low cycles", 32'(lowCount), 32'd5);
    checkOutput("t6 word_count", 32'(word_count), 32'd2);
    checkOutput("t6 mem0", mem[0], 32'hBEEF_0010);
    checkOutput("t6 mem1", mem[1], 32'hBEEF_0020);
    checkOutput("t6 address", instruction_initialize_address, 32'd4);

    idle();
    compareEn = 1'b0;
    $display("%0d/%0d checks passed", checksPassed, checksTotal);
    $finish;
  end

endmodule

// File: doc/cpu_boot_sequencer.md
# cpu_boot_sequencer

Controller that sequences the single-cycle CPU through load → settle → run → halt. It accepts a stream of instruction words over a valid/ready handshake and writes them into CPU instruction memory through the `initialize` port, holding the CPU in reset while it does so. It then releases reset for a programmable number of cycles, or until aborted, and parks the CPU back in reset. It sits between the host/bench stimulus and the `cpu` top.

## Interface

Parameters:
- `MAX_WORDS`, 64: instruction-memory capacity in words. Must be ≥ 2.
- `SETTLE_CYCLES`, 4: cycles `initialize` and `cpu_rst` stay high after the last word is accepted. Must be ≥ 1.
- `CNT_W`, `$clog2(MAX_WORDS+1)`: width of `word_count`.

Ports (name, direction, width, meaning):
- `clk` in 1: the single clock; all state updates on the rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `start` in 1: begin a load; sampled in IDLE and HALT only.
- `run_cycles` in 32: run length in cycles; 0 = unbounded. Latched when `start` is accepted.
- `abort` in 1: force HALT from LOAD, SETTLE or RUN.
- `word_valid` in 1: a loader word is present.
- `word_data` in 32: the instruction word.
- `word_last` in 1: marks the final word of the program.
- `word_ready` out 1: `state==LOAD`; combinational.
- `initialize` out 1: to `cpu.initialize`.
- `instruction_initialize_address` out 32: byte address to the CPU.
- `instruction_initialize_data` out 32: write data to the CPU.
- `cpu_rst` out 1: active-high reset to `cpu.rst`.
- `running` out 1: high in RUN.
- `done` out 1: high in HALT.
- `error` out 1: program overflowed `MAX_WORDS`; sticky until the next accepted `start`.
- `word_count` out CNT_W: number of words accepted in the current load.

## Operation

- States: IDLE, LOAD, SETTLE, RUN, HALT. Encoding is free.
- Reset values: state IDLE, `cpu_rst`=1, `initialize`=0, `instruction_initialize_address`=0, `instruction_initialize_data`=0, `running`=0, `done`=0, `error`=0, `word_count`=0, run counter=0.
- IDLE:
  - `cpu_rst`=1, `initialize`=0.
  - `start` → LOAD. On entry: clear `word_count` and `error`, latch `run_cycles`.
- LOAD:
  - `initialize`=1, `cpu_rst`=1.
  - A handshake (`word_valid && word_ready`) registers address = `word_count`×4, registers data = `word_data`, and increments `word_count`.
  - `word_last` on the handshake → SETTLE.
  - Handshake that makes `word_count`==`MAX_WORDS` without `word_last` → HALT with `error`=1. The CPU is never released.
- SETTLE:
  - `initialize`=1, `cpu_rst`=1, address/data held.
  - Stays exactly `SETTLE_CYCLES` cycles, then → RUN.
- RUN:
  - `initialize`=0, `cpu_rst`=0, `running`=1.
  - The 32-bit run counter increments every RUN cycle.
  - If latched `run_cycles`≠0 and counter reaches `run_cycles` → HALT. `cpu_rst` is low for exactly `run_cycles` cycles.
  - The counter saturates at all-ones.
- HALT:
  - `cpu_rst`=1, `initialize`=0, `done`=1.
  - `start` → LOAD, with the same entry actions as from IDLE.
- `abort` in LOAD/SETTLE/RUN → HALT at the next edge. A handshake in the same cycle as `abort` is discarded: no count, no address/data update.
- `abort` in IDLE is ignored. In HALT, `abort`+`start` together → stays in HALT.
- `start` in LOAD/SETTLE/RUN is ignored.
- `word_valid` outside LOAD is ignored (`word_ready`=0).

## Timing

- `start` sampled at edge N → LOAD from N; `word_ready`=1 in cycle N+1.
- Handshake at edge K → address/data visible after K. The CPU writes them on edge K+1, since `initialize` is still high.
- Last handshake at edge L:
  - SETTLE occupies cycles L..L+`SETTLE_CYCLES`−1.
  - `cpu_rst` falls after edge L+`SETTLE_CYCLES`.
- `cpu_rst` rises the edge the run counter hits `run_cycles`; `done` rises on the same edge.
- `rst` low clears all outputs immediately, with no clock needed, including mid-LOAD or mid-RUN. The CPU is held in reset (`cpu_rst`=1) throughout.
- Back-to-back handshakes every cycle are supported. `word_valid` gaps produce no address skips or duplicates.

## Test plan

- Load 3 words (0x00021020, 0x00844022, 0x00A63825), last on the 3rd, `run_cycles`=10 → writes at 0/4/8 with matching data; `word_count`=3; `cpu_rst` high through 4 SETTLE cycles, then low exactly 10 cycles; `done`=1, `running`=0.
- Same program with `word_valid` toggled 1-0-0-1-0-1 → addresses 0, 4, 8 only, each written once; `word_ready` high throughout LOAD.
- `MAX_WORDS`=4, 5 words, no `word_last` → 4 accepted; `error`=1; state HALT; `word_ready`=0 for the 5th; `cpu_rst` never low.
- `run_cycles`=0, `abort` pulsed on the 20th RUN cycle → `cpu_rst`=1 and `done`=1 next edge; `cpu_rst` was low exactly 20 cycles.
- `rst` low for 3 ns, between edges, mid-LOAD after 2 words → all outputs at reset values before the next edge; then `start` plus 1 word → written at address 0, `error`=0.
- In HALT, `start` with new `run_cycles`=5 → new load from address 0, run 5 cycles. `start` pulsed during RUN → no effect on the counter or state.
